// File: rtl/layer_background_scroll.sv
// Scrolling, palettised background layer: maps screen counters to a wrapped source pixel,
// fetches its word from block memory and emits the palette colour MEM_LAT+2 cycles later.
module layer_background_scroll #(
    parameter int IMG_W       = 320,
    parameter int IMG_H       = 240,
    parameter int BPP         = 4,
    parameter int MEM_DW      = 8,
    parameter int MEM_AW      = 16,
    parameter int SCALE_SHIFT = 1,
    parameter int MEM_LAT     = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [9:0]        h_cnt,
    input  logic [9:0]        v_cnt,
    input  logic              valid_in,
    input  logic              scroll_we,
    input  logic [9:0]        scroll_x_in,
    input  logic [9:0]        scroll_y_in,
    input  logic              pal_we,
    input  logic [BPP-1:0]    pal_idx,
    input  logic [11:0]       pal_data,
    output logic [MEM_AW-1:0] mem_addr,
    input  logic [MEM_DW-1:0] mem_data,
    output logic [11:0]       pixel,
    output logic              pixel_valid
);

    localparam int PPW  = MEM_DW / BPP;
    localparam int LW   = (PPW > 1) ? $clog2(PPW) : 1;
    localparam int NPAL = 2 ** BPP;
    localparam int GSH  = (BPP <= 4) ? (4 - BPP) : 0;
    localparam logic [10:0] IMG_W_L = 11'(IMG_W);
    localparam logic [10:0] IMG_H_L = 11'(IMG_H);

    function automatic logic [11:0] grey_entry(input int i);
        logic [3:0] g;
        if (BPP <= 4) g = 4'(i << GSH);
        else          g = 4'(i >> 4);
        return {g, g, g};
    endfunction

    logic [9:0]  shadow_x, shadow_y;
    logic [9:0]  act_x, act_y;
    logic [9:0]  eff_x, eff_y;
    logic        frame_commit;
    logic [10:0] sum_x, sum_y;
    logic [9:0]  sx, sy;
    logic [31:0] lin_idx;

    logic [LW-1:0]  lane_a;
    logic           valid_a;
    logic [LW-1:0]  lane_d [MEM_LAT];
    logic [MEM_LAT-1:0] valid_d;
    logic [BPP-1:0] pal_sel;
    logic [11:0]    palette [NPAL];

    assign frame_commit = (h_cnt == 10'd0) && (v_cnt == 10'd0);

    // The first pixel of a frame already sees the value being committed, so the whole frame is uniform.
    always_comb begin
        eff_x   = frame_commit ? shadow_x : act_x;
        eff_y   = frame_commit ? shadow_y : act_y;
        sum_x   = {1'b0, h_cnt >> SCALE_SHIFT} + {1'b0, eff_x};
        sum_y   = {1'b0, v_cnt >> SCALE_SHIFT} + {1'b0, eff_y};
        sx      = (sum_x >= IMG_W_L) ? 10'(sum_x - IMG_W_L) : sum_x[9:0];
        sy      = (sum_y >= IMG_H_L) ? 10'(sum_y - IMG_H_L) : sum_y[9:0];
        lin_idx = 32'(sy) * 32'(IMG_W) + 32'(sx);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_x <= '0;
            shadow_y <= '0;
            act_x    <= '0;
            act_y    <= '0;
        end else begin
            if (scroll_we && ({1'b0, scroll_x_in} < IMG_W_L) && ({1'b0, scroll_y_in} < IMG_H_L)) begin
                shadow_x <= scroll_x_in;
                shadow_y <= scroll_y_in;
            end
            if (frame_commit) begin
                act_x <= shadow_x;
                act_y <= shadow_y;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_addr <= '0;
            valid_a  <= 1'b0;
            valid_d  <= '0;
        end else begin
            mem_addr   <= MEM_AW'(lin_idx / PPW);
            valid_a    <= valid_in;
            valid_d[0] <= valid_a;
            for (int k = 1; k < MEM_LAT; k++) valid_d[k] <= valid_d[k-1];
        end
    end

    // Lane indices travel alongside the memory read; only the valid bits need clearing.
    always_ff @(posedge clk) begin
        lane_a    <= LW'(lin_idx % PPW);
        lane_d[0] <= lane_a;
        for (int k = 1; k < MEM_LAT; k++) lane_d[k] <= lane_d[k-1];
    end

    always_comb begin
        pal_sel = '0;
        for (int k = 0; k < PPW; k++) begin
            if (lane_d[MEM_LAT-1] == LW'(k)) pal_sel = mem_data[k*BPP +: BPP];
        end
    end

    // A write lands at the same edge as a lookup of that entry, so the lookup returns the old colour.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NPAL; i++) palette[i] <= grey_entry(i);
        end else if (pal_we) begin
            palette[pal_idx] <= pal_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pixel       <= 12'h000;
            pixel_valid <= 1'b0;
        end else if (valid_d[MEM_LAT-1]) begin
            pixel       <= palette[pal_sel];
            pixel_valid <= 1'b1;
        end else begin
            pixel       <= 12'h000;
            pixel_valid <= 1'b0;
        end
    end

endmodule

// File: doc/layer_background_scroll.md
LAYER_BACKGROUND_SCROLL -- requirements
Module: layer_background_scroll

Interface
REQ-001 Parameter IMG_W, default 320: source image width in pixels.
REQ-002 Parameter IMG_H, default 240: source image height in pixels.
REQ-003 Parameter BPP, default 4, legal 1/2/4/8: bits per palette index.
REQ-004 Parameter MEM_DW, default 8, a multiple of BPP: memory word width; PPW = MEM_DW/BPP pixels per word.
REQ-005 Parameter MEM_AW, default 16: memory word address width.
REQ-006 Parameter SCALE_SHIFT, default 1: screen-to-source downscale, applied as count >> SCALE_SHIFT.
REQ-007 Parameter MEM_LAT, default 1, range 1..4: memory read latency in cycles.
REQ-008 clk  in  1  single clock; all state updates on its rising edge.
REQ-009 rst  in  1  reset, synchronous, active-high.
REQ-010 h_cnt  in  10  horizontal screen counter.
REQ-011 v_cnt  in  10  vertical screen counter.
REQ-012 valid_in  in  1  high while the display is in the active region.
REQ-013 scroll_we  in  1  write strobe for the scroll shadow registers.
REQ-014 scroll_x_in  in  10  requested horizontal scroll in source pixels.
REQ-015 scroll_y_in  in  10  requested vertical scroll in source pixels.
REQ-016 pal_we  in  1  palette write strobe.
REQ-017 pal_idx  in  BPP  palette entry to write.
REQ-018 pal_data  in  12  RGB444 value to write.
REQ-019 mem_addr  out  MEM_AW  registered word address to the block memory.
REQ-020 mem_data  in  MEM_DW  memory read data, valid MEM_LAT cycles after mem_addr.
REQ-021 pixel  out  12  RGB444 output pixel, registered.
REQ-022 pixel_valid  out  1  high when pixel carries an active-region pixel.

Function
REQ-023 Coordinates shall be sx = ((h_cnt>>SCALE_SHIFT) + act_x) mod IMG_W and sy = ((v_cnt>>SCALE_SHIFT) + act_y) mod IMG_H, each computed with a single conditional subtract.
REQ-024 Linear index p = sy*IMG_W + sx; mem_addr = p / PPW; lane = p mod PPW.
REQ-025 Lane 0 shall occupy mem_data[BPP-1:0]; lane k occupies bits [k*BPP +: BPP].
REQ-026 Pipeline shall be: stage A registers mem_addr, lane and valid; MEM_LAT delay stages carry lane and valid; a final stage selects the lane, looks up the palette and registers pixel.
REQ-027 Total latency from h_cnt/v_cnt/valid_in to pixel/pixel_valid shall be exactly MEM_LAT+2 cycles, one result per cycle, with no stalls.
REQ-028 When the delayed valid is 0, pixel shall be 12'h000 and pixel_valid shall be 0.
REQ-029 A scroll_we write shall update shadow_x/shadow_y only if scroll_x_in < IMG_W and scroll_y_in < IMG_H; otherwise the whole write is ignored.
REQ-030 act_x/act_y shall load from the shadow registers only on the cycle where h_cnt==0 and v_cnt==0 (frame commit), so scroll never tears mid-frame.
REQ-031 If scroll_we and frame commit fall on the same cycle, the commit shall use the pre-write shadow value; the new value applies from the next frame.
REQ-032 The palette shall be a register file of 2**BPP x 12 bits, written on pal_we with pal_data at pal_idx.
REQ-033 If a palette write and a lookup of the same index fall on the same cycle, the lookup shall return the old value; the new value is visible from the next cycle.
REQ-034 The palette shall never clip on a partial update; entries not being written keep their values.

Reset
REQ-035 On rst: pixel=12'h000, pixel_valid=0, mem_addr=0, all pipeline valid bits=0, shadow_x/y=0, act_x/y=0.
REQ-036 On rst, palette entry i shall reset to the grey value g,g,g, where g = i << (4-BPP) for BPP<=4 and g = i[7:4] for BPP=8 (BPP=4: entry 5 = 12'h555).
REQ-037 Reset asserted mid-frame shall flush in-flight pixels; no pre-reset pixel_valid shall appear after reset.

Verification
REQ-038 Defaults, after reset, h=10,v=4,valid_in=1: mem_addr=(2*320+5)/2=322, lane 1; mem_data=8'hA3 -> pixel=12'hAAA with pixel_valid, 3 cycles after input.
REQ-039 Scroll wrap: scroll_x_in=318 written, then frame commit, h=8: sx=(4+318)-320=2 -> mem_addr=1, lane 0; the write takes no effect before the commit.
REQ-040 Illegal scroll: scroll_x_in=320 -> the shadow registers are unchanged and the next frame uses the previous scroll.
REQ-041 Palette hazard: pal_we at idx 3 with 12'hF00 on the same cycle as a lookup of idx 3 -> the old 12'h333 is output; the next lookup of idx 3 gives 12'hF00.
REQ-042 Blanking/reset: valid_in=0 -> pixel=0 and pixel_valid=0 after the latency; rst mid-stream -> the outputs are 0 on the next cycle and the in-flight pixels are discarded.
REQ-043 Param sweep BPP=2, MEM_DW=8, MEM_LAT=3: 4 pixels per word, lane=p[1:0], latency 5 cycles, checked over a full frame against a reference model.
